// File: rtl/cic_decimator_mr_if.sv
// cic_decimator_mr_if: sample stream into and decimated stream out of the CIC decimator.
interface cic_decimator_mr_if #(
    parameter int DW = 16
);
    logic [2:0]           os_sel;
    logic                 in_valid;
    logic signed [DW-1:0] data_in;
    logic                 out_valid;
    logic signed [DW-1:0] data_out;
    logic                 settling;
    modport master (output os_sel, in_valid, data_in, input out_valid, data_out, settling);
    modport slave (input os_sel, in_valid, data_in, output out_valid, data_out, settling);
endinterface

// File: rtl/cic_decimator_mr.sv
// cic_decimator_mr: run-time selectable 2^R CIC decimator; a rate change flushes the
// filter and hides the first ORDER outputs while the combs refill.
module cic_decimator_mr #(
    parameter int DW = 16,
    parameter int ORDER = 3,
    parameter int MAX_OS = 7
) (
    input logic clk,
    input logic reset_n,
    cic_decimator_mr_if.slave s
);
    localparam int AW = DW + ORDER * MAX_OS;
    localparam int CW = MAX_OS;
    logic [2:0] os_c, r_act, r_eff, settle_cnt;
    logic fresh, chg, acc, last, dec_q, cv;
    logic [CW-1:0] cnt, lim;
    logic signed [AW-1:0] integ [ORDER];
    logic signed [AW-1:0] integ_n [ORDER];
    logic signed [AW-1:0] dly [ORDER];
    logic signed [AW-1:0] comb_n [ORDER];
    logic signed [AW-1:0] comb_out;
    logic signed [DW-1:0] scaled;
    // The first edge after reset adopts os_sel directly, so it needs no flush.
    always_comb begin
        os_c = (s.os_sel > 3'(MAX_OS)) ? 3'(MAX_OS) : s.os_sel;
        r_eff = fresh ? os_c : r_act;
        chg = !fresh && (os_c != r_act);
        acc = s.in_valid && !chg && (r_eff != 3'd0);
        lim = CW'((32'd1 << r_eff) - 32'd1);
        last = cnt == lim;
        integ_n[0] = integ[0] + {{(AW-DW){s.data_in[DW-1]}}, s.data_in};
        for (int i = 1; i < ORDER; i++) integ_n[i] = integ[i] + integ_n[i-1];
        comb_n[0] = integ[ORDER-1] - dly[0];
        for (int i = 1; i < ORDER; i++) comb_n[i] = comb_n[i-1] - dly[i];
        scaled = DW'(comb_out >>> (ORDER * r_act));
    end
    assign s.settling = (settle_cnt != 3'd0) && (r_eff != 3'd0);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fresh <= 1'b1;
            r_act <= 3'd0;
            cnt <= '0;
            dec_q <= 1'b0;
            cv <= 1'b0;
            comb_out <= '0;
            integ <= '{default: '0};
            dly <= '{default: '0};
            settle_cnt <= 3'(ORDER);
            s.out_valid <= 1'b0;
            s.data_out <= '0;
        end else if (chg) begin
            r_act <= os_c;
            cnt <= '0;
            dec_q <= 1'b0;
            cv <= 1'b0;
            comb_out <= '0;
            integ <= '{default: '0};
            dly <= '{default: '0};
            settle_cnt <= 3'(ORDER);
            s.out_valid <= 1'b0;
        end else begin
            fresh <= 1'b0;
            r_act <= r_eff;
            if (acc) begin
                integ <= integ_n;
                cnt <= last ? '0 : cnt + CW'(1);
            end
            dec_q <= acc && last;
            cv <= dec_q;
            if (dec_q) begin
                dly[0] <= integ[ORDER-1];
                for (int i = 1; i < ORDER; i++) dly[i] <= comb_n[i-1];
                comb_out <= comb_n[ORDER-1];
            end
            if (r_eff == 3'd0) begin
                s.out_valid <= s.in_valid;
                if (s.in_valid) s.data_out <= s.data_in;
            end else if (cv && settle_cnt != 3'd0) begin
                settle_cnt <= settle_cnt - 3'd1;
                s.out_valid <= 1'b0;
            end else begin
                s.out_valid <= cv;
                if (cv) s.data_out <= scaled;
            end
        end
    end
endmodule
